// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state width and encodings.
package serial_adder_ctrl_pkg;

  localparam int unsigned ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_half_adder_cell.sv
// Combinational half-adder cell; two of these plus an OR form one full-adder bit slice.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder slice reused LSB-first,
// registered sum/carry-out and a one-cycle done strobe.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-2:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               ha0_s, ha0_c, ha1_s, ha1_c;
  logic               bit_s, bit_c;
  logic [WIDTH-1:0]   sum_next;

  // Full-adder slice on the current LSBs and the running carry
  half_adder_cell u_ha0 (.x(a_sh_q[0]), .y(b_sh_q[0]), .s(ha0_s), .c(ha0_c));
  half_adder_cell u_ha1 (.x(ha0_s),     .y(carry_q),   .s(ha1_s), .c(ha1_c));

  assign bit_s    = ha1_s;
  assign bit_c    = ha0_c | ha1_c;
  // Partial sum with the new bit shifted in; the lowest bit leaves s_sh here
  assign sum_next = {bit_s, s_sh_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = sum_next[WIDTH-1:1];
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_next;
          cout_d  = bit_c;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random adds against an
// arithmetic reference, plus busy-ignore, hold, back-to-back and abort scenarios.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned MAX_WAIT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain WIDTH+1 bit addition
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Issue one add and run until done; returns observed result and timing
  task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output logic [WIDTH-1:0] got_sum, output logic got_cout,
                        output int lat, output int busy_cnt, output int overlap);
    start = 1'b1; a = x; b = y;
    tick();
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!done && lat < int'(MAX_WAIT)) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (busy && done) overlap++;
    got_sum = sum; got_cout = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'h5A; b = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 ||
          dut.state_q !== ST_IDLE) begin
        n_fail++;
        $display("FAIL reset_hold: busy=%b done=%b sum=%h cout=%b state=%0d, want 0 0 00 0 %0d",
                 busy, done, sum, cout, dut.state_q, ST_IDLE);
      end
    end
    start = 1'b0;
    rst = 1'b0;
    tick();
    n_tests++;
    if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d busy=%b, want %0d 0", dut.state_q, busy, ST_IDLE);
    end
  endtask

  task automatic check_add(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] gs; logic gc; int lat, bc, ov;
    logic [WIDTH:0] exp_v;
    exp_v = ref_add(x, y);
    do_add(x, y, gs, gc, lat, bc, ov);
    n_tests++;
    if ({gc, gs} !== exp_v) begin
      n_fail++;
      $display("FAIL %s_result: a=%h b=%h got cout=%b sum=%h, want cout=%b sum=%h",
               name, x, y, gc, gs, exp_v[WIDTH], exp_v[WIDTH-1:0]);
    end
    n_tests++;
    if (lat != int'(WIDTH) || bc != int'(WIDTH) || ov != 0) begin
      n_fail++;
      $display("FAIL %s_timing: done_after=%0d busy_cycles=%0d overlap=%0d, want %0d %0d 0",
               name, lat, bc, ov, WIDTH, WIDTH);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s_strobe: done=%b busy=%b state=%0d after done cycle, want 0 0 %0d",
               name, done, busy, dut.state_q, ST_IDLE);
    end
  endtask

  task automatic test_directed();
    check_add("basic",  8'h05, 8'h03);
    check_add("ripple", 8'hFF, 8'h01);
    check_add("alt",    8'hA5, 8'h5A);
    check_add("ones",   8'hFF, 8'hFF);
    check_add("zero",   8'h00, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      check_add("rand", WIDTH'($urandom), WIDTH'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_busy_ignore();
    logic [WIDTH-1:0] x, y; logic [WIDTH:0] exp_v; int n, dones;
    x = 8'h37; y = 8'h4C;
    exp_v = ref_add(x, y);
    start = 1'b1; a = x; b = y;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; a = 8'h11; b = 8'h22;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < int'(MAX_WAIT)) begin tick(); n++; end
    n_tests++;
    if (!done || {cout, sum} !== exp_v) begin
      n_fail++;
      $display("FAIL busy_ignore_result: done=%b cout=%b sum=%h, want 1 %b %h",
               done, cout, sum, exp_v[WIDTH], exp_v[WIDTH-1:0]);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
      n_tests++;
      if ({cout, sum} !== exp_v || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_idle: cycle %0d busy=%b cout=%b sum=%h, want 0 %b %h",
                 i, busy, cout, sum, exp_v[WIDTH], exp_v[WIDTH-1:0]);
      end
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL busy_ignore_extra_done: got %0d extra done strobes, want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] gs; logic gc; int lat, bc, ov, gap;
    logic [WIDTH:0] exp_v;
    do_add(8'h21, 8'h42, gs, gc, lat, bc, ov);
    n_tests++;
    if (!done || gs !== 8'h63) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b sum=%h, want 1 63", done, gs);
    end
    start = 1'b1; a = 8'h10; b = 8'h20;
    exp_v = ref_add(8'h10, 8'h20);
    tick();
    start = 1'b0;
    gap = 1;
    n_tests++;
    if (busy !== 1'b1 || dut.state_q !== ST_RUN) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: busy=%b state=%0d, want 1 %0d", busy, dut.state_q, ST_RUN);
    end
    while (!done && gap < int'(MAX_WAIT)) begin tick(); gap++; end
    n_tests++;
    if (gap != int'(WIDTH) + 1 || {cout, sum} !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_second: gap=%0d cout=%b sum=%h, want %0d %b %h",
               gap, cout, sum, WIDTH + 1, exp_v[WIDTH], exp_v[WIDTH-1:0]);
    end
    tick();
  endtask

  task automatic test_abort();
    int dones;
    start = 1'b1; a = 8'hC3; b = 8'h7E;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 ||
        dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b state=%0d, want 0 0 00 0 %0d",
               busy, done, sum, cout, dut.state_q, ST_IDLE);
    end
    dones = 0;
    for (int i = 0; i < int'(WIDTH) + 4; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: saw %0d busy/done cycles after abort, want 0", dones);
    end
    check_add("post_abort", 8'h80, 8'h80);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
